// File: rtl/mio_pkg.sv
// ============================================================================
//  Module   : mio_pkg
//  Desc     : Shared FSM encoding and IO address map for the MIO responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } mio_state_e;

    localparam logic [3:0]  IO_REGION = 4'hF;
    localparam logic [31:0] IO_LED    = 32'hF000_0000;
    localparam logic [31:0] IO_SW     = 32'hF000_0004;
    localparam logic [31:0] IO_CNT    = 32'hF000_0008;

endpackage

`default_nettype wire

// File: rtl/mio_ram.sv
// ============================================================================
//  Module   : mio_ram
//  Desc     : Single-port word RAM, synchronous write, read-enabled
//             registered read port.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_ram #(
    parameter int RAM_WORDS = 1024,
    parameter int ADDR_W    = $clog2(RAM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [RAM_WORDS];
    logic [31:0] r_rdata;

    // Read port only updates on enable so the output holds between reads.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mio_responder.sv
// ============================================================================
//  Module   : mio_responder
//  Desc     : MIO bus responder - RAM and register-mapped IO with fixed
//             wait states, sticky error flag and one-cycle ready strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mio_responder
    import mio_pkg::*;
#(
    parameter int RAM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] addr,
    input  logic [31:0] Data_in,
    output logic [31:0] Data_out,
    output logic        MIO_ready,
    input  logic [15:0] sw,
    output logic [15:0] led,
    output logic        bus_err
);

    localparam int         c_aw        = $clog2(RAM_WORDS);
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    mio_state_e  r_state, w_state_nxt;
    logic [3:0]  r_wait, w_wait_nxt;
    logic [31:0] r_addr, r_wdata;
    logic        r_rd, r_wr;
    logic [15:0] r_led, r_sw_meta, r_sw_sync;
    logic [31:0] r_cycle, r_io_rdata;
    logic        r_err, r_src_ram;

    logic [31:0] w_cur_addr, w_cur_wdata, w_waddr, w_io_rdata, w_ram_rdata;
    logic        w_cur_rd, w_cur_wr;
    logic        w_req, w_accept, w_commit;
    logic        w_is_io, w_ram_ok, w_hit_led, w_hit_sw, w_hit_cnt, w_err;
    logic        w_do_wr, w_do_rd;
    logic        w_unused_lat, w_unused_lsb;

    assign w_req    = CPU_MIO & (MemRead | MemWrite);
    assign w_accept = (r_state == ST_IDLE) & w_req;

    // With no wait states the whole access resolves on the accepting edge,
    // so decode must look at the live bus rather than the latched copy.
    generate
        if (WAIT_CYCLES == 0) begin : g_direct
            assign w_cur_addr   = addr;
            assign w_cur_wdata  = Data_in;
            assign w_cur_rd     = MemRead;
            assign w_cur_wr     = MemWrite;
            assign w_unused_lat = ^{r_addr, r_wdata, r_rd, r_wr};
        end else begin : g_latched
            assign w_cur_addr   = r_addr;
            assign w_cur_wdata  = r_wdata;
            assign w_cur_rd     = r_rd;
            assign w_cur_wr     = r_wr;
            assign w_unused_lat = 1'b0;
        end
    endgenerate

    assign w_unused_lsb = ^w_cur_addr[1:0];
    assign w_waddr      = {w_cur_addr[31:2], 2'b00};
    assign w_is_io      = (w_cur_addr[31:28] == IO_REGION);
    assign w_ram_ok     = !w_is_io && (w_cur_addr[31:c_aw+2] == '0);
    assign w_hit_led    = w_is_io && (w_waddr == IO_LED);
    assign w_hit_sw     = w_is_io && (w_waddr == IO_SW);
    assign w_hit_cnt    = w_is_io && (w_waddr == IO_CNT);
    assign w_err        = (w_cur_rd & w_cur_wr)
                        | (!w_is_io & !w_ram_ok)
                        | (w_is_io & !(w_hit_led | w_hit_sw | w_hit_cnt));
    assign w_do_wr      = w_commit & w_cur_wr & !w_err & !rst;
    assign w_do_rd      = w_commit & w_cur_rd & !w_err & !rst;

    always_comb begin
        w_io_rdata = 32'd0;
        if (w_hit_led) begin
            w_io_rdata = {16'd0, r_led};
        end else if (w_hit_sw) begin
            w_io_rdata = {16'd0, r_sw_sync};
        end else if (w_hit_cnt) begin
            w_io_rdata = r_cycle;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_wait_nxt = c_wait_load;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = ST_ACK;
                        w_commit    = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (r_wait == 4'd0) begin
                    w_state_nxt = ST_ACK;
                    w_commit    = 1'b1;
                end else begin
                    w_wait_nxt = r_wait - 4'd1;
                end
            end
            ST_ACK:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait     <= 4'd0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_rd       <= 1'b0;
            r_wr       <= 1'b0;
            r_led      <= 16'd0;
            r_sw_meta  <= 16'd0;
            r_sw_sync  <= 16'd0;
            r_cycle    <= 32'd0;
            r_io_rdata <= 32'd0;
            r_err      <= 1'b0;
            r_src_ram  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_wait    <= w_wait_nxt;
            r_sw_meta <= sw;
            r_sw_sync <= r_sw_meta;
            if (w_accept) begin
                r_addr  <= addr;
                r_wdata <= Data_in;
                r_rd    <= MemRead;
                r_wr    <= MemWrite;
            end
            r_cycle <= (w_do_wr && w_hit_cnt) ? 32'd0 : r_cycle + 32'd1;
            if (w_do_wr && w_hit_led) begin
                r_led <= w_cur_wdata[15:0];
            end
            if (w_commit && w_err) begin
                r_err <= 1'b1;
            end
            // Read data source is chosen at commit; RAM data arrives in the
            // RAM's own output register on the same edge.
            if (w_commit && w_cur_rd) begin
                if (w_err) begin
                    r_src_ram  <= 1'b0;
                    r_io_rdata <= 32'd0;
                end else if (w_ram_ok) begin
                    r_src_ram <= 1'b1;
                end else begin
                    r_src_ram  <= 1'b0;
                    r_io_rdata <= w_io_rdata;
                end
            end
        end
    end

    mio_ram #(
        .RAM_WORDS (RAM_WORDS)
    ) u_ram (
        .clk   (clk),
        .we    (w_do_wr & w_ram_ok),
        .re    (w_do_rd & w_ram_ok),
        .addr  (w_cur_addr[c_aw+1:2]),
        .wdata (w_cur_wdata),
        .rdata (w_ram_rdata)
    );

    assign Data_out  = r_src_ram ? w_ram_rdata : r_io_rdata;
    assign MIO_ready = (r_state == ST_ACK);
    assign led       = r_led;
    assign bus_err   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mio_responder.sv
// ============================================================================
//  Module   : tb_mio_responder
//  Desc     : Directed vector bench for mio_responder (default timing and a
//             zero-wait-state instance).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mio_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mio0 = 1'b0, mio1 = 1'b0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [31:0] addr = 32'd0, din = 32'd0;
    logic [15:0] sw = 16'd0;
    logic [31:0] dout0, dout1;
    logic        rdy0, rdy1, err0, err1;
    logic [15:0] led0, led1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mio_responder #(.RAM_WORDS(1024), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .CPU_MIO(mio0), .MemRead(rd), .MemWrite(wr),
        .addr(addr), .Data_in(din), .Data_out(dout0), .MIO_ready(rdy0),
        .sw(sw), .led(led0), .bus_err(err0)
    );

    mio_responder #(.RAM_WORDS(1024), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .CPU_MIO(mio1), .MemRead(rd), .MemWrite(wr),
        .addr(addr), .Data_in(din), .Data_out(dout1), .MIO_ready(rdy1),
        .sw(sw), .led(led1), .bus_err(err1)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [15:0] sw;
        logic [31:0] exp_data;
        logic [15:0] exp_led;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // One access on the selected instance; returns cycles from accept to ready.
    task automatic do_access(input int which, input logic r, input logic w,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat);
        @(negedge clk);
        rd = r; wr = w; addr = a; din = d;
        if (which == 0) mio0 = 1'b1; else mio1 = 1'b1;
        @(posedge clk);
        #1;
        mio0 = 1'b0; mio1 = 1'b0; rd = 1'b0; wr = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if ((which == 0) ? rdy0 : rdy1) break;
            @(posedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[14];
        int   lat;
        logic seen;

        vecs[0]  = '{"wr_ram10",   1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0000, 32'h0000_0000, 16'h0000, 1'b0};
        vecs[1]  = '{"rd_ram10",   1'b1, 1'b0, 32'h0000_0010, 32'h0,         16'h0000, 32'hDEAD_BEEF, 16'h0000, 1'b0};
        vecs[2]  = '{"wr_ram8",    1'b0, 1'b1, 32'h0000_0008, 32'h1111_1111, 16'h0000, 32'hDEAD_BEEF, 16'h0000, 1'b0};
        vecs[3]  = '{"wr_led",     1'b0, 1'b1, 32'hF000_0000, 32'h1234_5678, 16'h0000, 32'hDEAD_BEEF, 16'h5678, 1'b0};
        vecs[4]  = '{"rd_led",     1'b1, 1'b0, 32'hF000_0000, 32'h0,         16'h0000, 32'h0000_5678, 16'h5678, 1'b0};
        vecs[5]  = '{"rd_sw",      1'b1, 1'b0, 32'hF000_0004, 32'h0,         16'hA5A5, 32'h0000_A5A5, 16'h5678, 1'b0};
        vecs[6]  = '{"wr_sw",      1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 16'hA5A5, 32'h0000_A5A5, 16'h5678, 1'b0};
        vecs[7]  = '{"rd_sw2",     1'b1, 1'b0, 32'hF000_0004, 32'h0,         16'hA5A5, 32'h0000_A5A5, 16'h5678, 1'b0};
        vecs[8]  = '{"rd_lsb_ign", 1'b1, 1'b0, 32'h0000_0013, 32'h0,         16'hA5A5, 32'hDEAD_BEEF, 16'h5678, 1'b0};
        vecs[9]  = '{"rd_oor",     1'b1, 1'b0, 32'h0001_0000, 32'h0,         16'hA5A5, 32'h0000_0000, 16'h5678, 1'b1};
        vecs[10] = '{"rd_unmap",   1'b1, 1'b0, 32'hF000_000C, 32'h0,         16'hA5A5, 32'h0000_0000, 16'h5678, 1'b1};
        vecs[11] = '{"rd_ram10b",  1'b1, 1'b0, 32'h0000_0010, 32'h0,         16'hA5A5, 32'hDEAD_BEEF, 16'h5678, 1'b1};
        vecs[12] = '{"rw_both",    1'b1, 1'b1, 32'h0000_0010, 32'h0,         16'hA5A5, 32'h0000_0000, 16'h5678, 1'b1};
        vecs[13] = '{"rd_ram10c",  1'b1, 1'b0, 32'h0000_0010, 32'h0,         16'hA5A5, 32'hDEAD_BEEF, 16'h5678, 1'b1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready0", {31'd0, rdy0}, 32'd0);
        check("rst_data0",  dout0, 32'd0);
        check("rst_led0",   {16'd0, led0}, 32'd0);
        check("rst_err0",   {31'd0, err0}, 32'd0);
        check("rst_ready1", {31'd0, rdy1}, 32'd0);
        check("rst_data1",  dout1, 32'd0);

        for (int i = 0; i < 14; i++) begin
            sw = vecs[i].sw;
            do_access(0, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, lat);
            check({vecs[i].name, "_lat"},  lat, 32'd3);
            check({vecs[i].name, "_data"}, dout0, vecs[i].exp_data);
            check({vecs[i].name, "_led"},  {16'd0, led0}, {16'd0, vecs[i].exp_led});
            check({vecs[i].name, "_err"},  {31'd0, err0}, {31'd0, vecs[i].exp_err});
        end

        // Reset lands while a write to 0x8 is still in WAIT.
        @(negedge clk);
        rd = 1'b0; wr = 1'b1; addr = 32'h0000_0008; din = 32'hFFFF_FFFF; mio0 = 1'b1;
        @(posedge clk);
        #1;
        mio0 = 1'b0; wr = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy0) seen = 1'b1;
        end
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy0) seen = 1'b1;
        end
        check("midrst_noready", {31'd0, seen}, 32'd0);
        check("midrst_led",     {16'd0, led0}, 32'd0);
        check("midrst_err",     {31'd0, err0}, 32'd0);
        check("midrst_data",    dout0, 32'd0);
        do_access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0, lat);
        check("rd_ram8_lat",  lat, 32'd3);
        check("rd_ram8_data", dout0, 32'h1111_1111);

        // Counter cleared by write commit; read 4 edges later sees 3.
        do_access(0, 1'b0, 1'b1, 32'hF000_0008, 32'h5555_5555, lat);
        check("wr_cnt_lat",  lat, 32'd3);
        check("wr_cnt_data", dout0, 32'h1111_1111);
        do_access(0, 1'b1, 1'b0, 32'hF000_0008, 32'h0, lat);
        check("rd_cnt_data", dout0, 32'd3);
        check("rd_cnt_err",  {31'd0, err0}, 32'd0);

        // Zero-wait-state instance.
        do_access(1, 1'b0, 1'b1, 32'h0000_0000, 32'hA0A0_A0A0, lat);
        check("w0_wr0_lat", lat, 32'd1);
        do_access(1, 1'b0, 1'b1, 32'h0000_0004, 32'hB4B4_B4B4, lat);
        check("w0_wr4_lat", lat, 32'd1);
        check("w0_err",     {31'd0, err1}, 32'd0);

        @(negedge clk);
        rd = 1'b1; wr = 1'b0; addr = 32'h0000_0000; mio1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_a",  {31'd0, rdy1}, 32'd1);
        check("b2b_data_a", dout1, 32'hA0A0_A0A0);
        addr = 32'h0000_0004;
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_gap", {31'd0, rdy1}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_b",  {31'd0, rdy1}, 32'd1);
        check("b2b_data_b", dout1, 32'hB4B4_B4B4);
        mio1 = 1'b0; rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("b2b_idle", {31'd0, rdy1}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
